// File: rtl/alu_pkg.sv
// alu_pkg: codes and constants shared by the operand-B stage and its bench.
//   bsel_e : operand-B source select (zero / rs2 / imm / constant 4)
//   fwd_e  : registered forwarding source tag (none / MEM / WB)
//   CONST4_VALUE : value loaded when bsel selects the constant source
package alu_pkg;

   typedef enum logic [1:0] {
      BSEL_ZERO   = 2'b00,
      BSEL_RS2    = 2'b01,
      BSEL_IMM    = 2'b10,
      BSEL_CONST4 = 2'b11
   } bsel_e;

   typedef enum logic [1:0] {
      FWD_NONE = 2'b00,
      FWD_MEM  = 2'b01,
      FWD_WB   = 2'b10
   } fwd_e;

   localparam int unsigned CONST4_VALUE = 4;

endpackage : alu_pkg

// File: rtl/alu_opb_stage_if.sv
// alu_opb_stage_if: upstream request, forward sources and downstream result
// of the operand-B stage, bundled as one bus.
//   slave  : seen by the stage (takes requests, drives in_ready/out_*)
//   master : seen by whoever drives the stage (pipeline or bench)
// Parameters XLEN / RADDR_W must match the stage instance.
interface alu_opb_stage_if #(
   parameter int XLEN    = 64,
   parameter int RADDR_W = 5
);
   logic               in_valid;
   logic               in_ready;
   logic [1:0]         bsel;
   logic               word_mode;
   logic [XLEN-1:0]    rs2;
   logic [XLEN-1:0]    imm;
   logic [RADDR_W-1:0] rs2_addr;
   logic               fwd_mem_we;
   logic [RADDR_W-1:0] fwd_mem_rd;
   logic [XLEN-1:0]    fwd_mem_data;
   logic               fwd_wb_we;
   logic [RADDR_W-1:0] fwd_wb_rd;
   logic [XLEN-1:0]    fwd_wb_data;
   logic               flush;
   logic               out_valid;
   logic               out_ready;
   logic [XLEN-1:0]    b_out;
   logic [1:0]         fwd_hit;

   modport slave (
      input  in_valid, bsel, word_mode, rs2, imm, rs2_addr,
      input  fwd_mem_we, fwd_mem_rd, fwd_mem_data,
      input  fwd_wb_we, fwd_wb_rd, fwd_wb_data,
      input  flush, out_ready,
      output in_ready, out_valid, b_out, fwd_hit
   );

   modport master (
      output in_valid, bsel, word_mode, rs2, imm, rs2_addr,
      output fwd_mem_we, fwd_mem_rd, fwd_mem_data,
      output fwd_wb_we, fwd_wb_rd, fwd_wb_data,
      output flush, out_ready,
      input  in_ready, out_valid, b_out, fwd_hit
   );

endinterface : alu_opb_stage_if

// File: rtl/alu_opb_fwd_sel.sv
// alu_opb_fwd_sel: combinational forward compare and priority for rs2.
//   rs2_i / rs2_addr_i        : register-file value and its index
//   mem_we_i/mem_rd_i/mem_data_i : MEM-stage forward source
//   wb_we_i/wb_rd_i/wb_data_i    : WB-stage forward source
//   data_o : forwarded value (MEM beats WB, else rs2_i)
//   hit_o  : source tag of data_o
// Register x0 is hard-wired zero, so it is never forwarded.
module alu_opb_fwd_sel
   import alu_pkg::*;
#(
   parameter int XLEN    = 64,
   parameter int RADDR_W = 5
) (
   input  logic [XLEN-1:0]    rs2_i,
   input  logic [RADDR_W-1:0] rs2_addr_i,
   input  logic               mem_we_i,
   input  logic [RADDR_W-1:0] mem_rd_i,
   input  logic [XLEN-1:0]    mem_data_i,
   input  logic               wb_we_i,
   input  logic [RADDR_W-1:0] wb_rd_i,
   input  logic [XLEN-1:0]    wb_data_i,
   output logic [XLEN-1:0]    data_o,
   output fwd_e               hit_o
);

   logic addr_nz;
   logic mem_hit;
   logic wb_hit;

   assign addr_nz = (rs2_addr_i != '0);
   assign mem_hit = mem_we_i && (mem_rd_i == rs2_addr_i) && addr_nz;
   assign wb_hit  = wb_we_i  && (wb_rd_i  == rs2_addr_i) && addr_nz;

   always_comb begin
      data_o = rs2_i;
      hit_o  = FWD_NONE;
      // MEM holds the younger write, so it wins over WB.
      if (mem_hit) begin
         data_o = mem_data_i;
         hit_o  = FWD_MEM;
      end else if (wb_hit) begin
         data_o = wb_data_i;
         hit_o  = FWD_WB;
      end
   end

endmodule : alu_opb_fwd_sel

// File: rtl/alu_opb_stage.sv
// alu_opb_stage: selects ALU operand B, optionally forwards rs2 from MEM/WB,
// optionally sign-extends a 32-bit W-op result, and holds it in a
// single-entry valid/ready register.
//   clk  : single clock, rising edge
//   rstn : asynchronous active-low reset (clears out_valid, b_out, fwd_hit)
//   bus  : alu_opb_stage_if.slave -- request, forward sources, flush,
//          out_valid/out_ready handshake, b_out and fwd_hit
// Build option: define ALU_OPB_FWD_EN to compile in MEM/WB forwarding.
// Without it bsel==01 always picks rs2, fwd_hit stays 00 and the forward
// inputs are ignored.
module alu_opb_stage
   import alu_pkg::*;
#(
   parameter int XLEN    = 64,
   parameter int RADDR_W = 5
) (
   input  logic              clk,
   input  logic              rstn,
   alu_opb_stage_if.slave    bus
);

   logic [XLEN-1:0] rs2_val;
   fwd_e            rs2_tag;
   logic [XLEN-1:0] sel_raw;
   logic [XLEN-1:0] sel_val;
   fwd_e            sel_tag;
   logic            accept;

   logic            valid_q, valid_d;
   logic [XLEN-1:0] b_q, b_d;
   fwd_e            hit_q, hit_d;

`ifdef ALU_OPB_FWD_EN
   alu_opb_fwd_sel #(
      .XLEN    (XLEN),
      .RADDR_W (RADDR_W)
   ) u_fwd_sel (
      .rs2_i      (bus.rs2),
      .rs2_addr_i (bus.rs2_addr),
      .mem_we_i   (bus.fwd_mem_we),
      .mem_rd_i   (bus.fwd_mem_rd),
      .mem_data_i (bus.fwd_mem_data),
      .wb_we_i    (bus.fwd_wb_we),
      .wb_rd_i    (bus.fwd_wb_rd),
      .wb_data_i  (bus.fwd_wb_data),
      .data_o     (rs2_val),
      .hit_o      (rs2_tag)
   );
`else
   assign rs2_val = bus.rs2;
   assign rs2_tag = FWD_NONE;

   // Forward inputs stay on the bus so both builds share one interface.
   logic unused_fwd;
   assign unused_fwd = ^{bus.rs2_addr, bus.fwd_mem_we, bus.fwd_mem_rd,
                         bus.fwd_mem_data, bus.fwd_wb_we, bus.fwd_wb_rd,
                         bus.fwd_wb_data};
`endif

   always_comb begin
      sel_raw = '0;
      case (bus.bsel)
         BSEL_ZERO: sel_raw = '0;
         BSEL_RS2:  sel_raw = rs2_val;
         BSEL_IMM:  sel_raw = bus.imm;
         default:   sel_raw = XLEN'(CONST4_VALUE);
      endcase
   end

   // The tag only means something when the rs2 path was actually chosen.
   assign sel_tag = (bus.bsel == BSEL_RS2) ? rs2_tag : FWD_NONE;

   // W-ops only exist on a wide datapath; on RV32 word_mode is a no-op.
   generate
      if (XLEN > 32) begin : g_word
         assign sel_val = bus.word_mode ? {{(XLEN-32){sel_raw[31]}}, sel_raw[31:0]}
                                        : sel_raw;
      end else begin : g_no_word
         assign sel_val = sel_raw;
         logic unused_word_mode;
         assign unused_word_mode = bus.word_mode;
      end
   endgenerate

   assign bus.in_ready = !valid_q || bus.out_ready;
   assign accept       = bus.in_valid && bus.in_ready && !bus.flush;

   always_comb begin
      valid_d = valid_q;
      b_d     = b_q;
      hit_d   = hit_q;
      if (bus.flush) begin
         // Flush beats both a stall and a same-cycle accept; b_out keeps
         // its stale value since out_valid already marks it dead.
         valid_d = 1'b0;
         hit_d   = FWD_NONE;
      end else if (accept) begin
         valid_d = 1'b1;
         b_d     = sel_val;
         hit_d   = sel_tag;
      end else if (bus.out_ready) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         valid_q <= 1'b0;
         b_q     <= '0;
         hit_q   <= FWD_NONE;
      end else begin
         valid_q <= valid_d;
         b_q     <= b_d;
         hit_q   <= hit_d;
      end
   end

   assign bus.out_valid = valid_q;
   assign bus.b_out     = b_q;
   assign bus.fwd_hit   = hit_q;

endmodule : alu_opb_stage

// File: tb/tb_alu_opb_stage.sv
// tb_alu_opb_stage: directed scenarios plus a randomized run of the
// operand-B stage, checked against a behavioural reference kept here.
// Expectations follow the build: with ALU_OPB_FWD_EN defined the reference
// forwards from MEM/WB, otherwise rs2 is always taken and fwd_hit is 00.
`timescale 1ns/1ps
module tb_alu_opb_stage;
   import alu_pkg::*;

   localparam int XLEN    = 64;
   localparam int RADDR_W = 5;

   logic clk;
   logic rstn;
   int   total;
   int   bad;

   alu_opb_stage_if #(.XLEN(XLEN), .RADDR_W(RADDR_W)) bus ();

   alu_opb_stage #(.XLEN(XLEN), .RADDR_W(RADDR_W)) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference operand: what the stage should load for the given request.
   function automatic void ref_op(
      input  logic [1:0]  bsel, input logic wm,
      input  logic [63:0] rs2, input logic [63:0] imm, input logic [4:0] addr,
      input  logic mwe, input logic [4:0] mrd, input logic [63:0] mdata,
      input  logic wwe, input logic [4:0] wrd, input logic [63:0] wdata,
      output logic [63:0] v, output logic [1:0] t);
      v = 64'd0;
      t = 2'b00;
      if (bsel == 2'b01) begin
         v = rs2;
`ifdef ALU_OPB_FWD_EN
         if (addr != 0 && mwe && mrd == addr) begin
            v = mdata; t = 2'b01;
         end else if (addr != 0 && wwe && wrd == addr) begin
            v = wdata; t = 2'b10;
         end
`endif
      end else if (bsel == 2'b10) v = imm;
      else if (bsel == 2'b11) v = 64'd4;
      if (wm) v = {{32{v[31]}}, v[31:0]};
   endfunction

   task automatic idle_inputs();
      bus.in_valid = 1'b0; bus.bsel = 2'b00; bus.word_mode = 1'b0;
      bus.rs2 = '0; bus.imm = '0; bus.rs2_addr = '0;
      bus.fwd_mem_we = 1'b0; bus.fwd_mem_rd = '0; bus.fwd_mem_data = '0;
      bus.fwd_wb_we = 1'b0; bus.fwd_wb_rd = '0; bus.fwd_wb_data = '0;
      bus.flush = 1'b0; bus.out_ready = 1'b1;
   endtask

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      idle_inputs();
      rstn = 1'b0;
      #3;
      total++;
      if ({bus.out_valid, bus.fwd_hit, bus.b_out} !== {1'b0, 2'b00, 64'd0}) begin
         bad++;
         $display("FAIL reset_state: got v=%b hit=%b b=%h need v=0 hit=00 b=0",
                  bus.out_valid, bus.fwd_hit, bus.b_out);
      end
      total++;
      if (bus.in_ready !== 1'b1) begin
         bad++;
         $display("FAIL reset_in_ready: got %b need 1", bus.in_ready);
      end
      @(posedge clk); #2 rstn = 1'b1;
      step();
   endtask

   task automatic test_imm();
      bus.bsel = 2'b10; bus.imm = 64'hFFFF_FFFF_FFFF_FFF0;
      bus.in_valid = 1'b1; bus.out_ready = 1'b1;
      step();
      total++;
      if ({bus.out_valid, bus.fwd_hit, bus.b_out} !== {1'b1, 2'b00, 64'hFFFF_FFFF_FFFF_FFF0}) begin
         bad++;
         $display("FAIL imm_load: got v=%b hit=%b b=%h need v=1 hit=00 b=fffffffffffffff0",
                  bus.out_valid, bus.fwd_hit, bus.b_out);
      end
      idle_inputs(); step();
   endtask

   task automatic test_forward();
      logic [63:0] e_b [3];
      logic [1:0]  e_t [3];
`ifdef ALU_OPB_FWD_EN
      e_b[0] = 64'h22; e_t[0] = 2'b01;
      e_b[1] = 64'h33; e_t[1] = 2'b10;
`else
      e_b[0] = 64'h11; e_t[0] = 2'b00;
      e_b[1] = 64'h11; e_t[1] = 2'b00;
`endif
      e_b[2] = 64'h11; e_t[2] = 2'b00;
      bus.in_valid = 1'b1; bus.out_ready = 1'b1; bus.bsel = 2'b01;
      bus.rs2 = 64'h11; bus.rs2_addr = 5'd5;
      bus.fwd_mem_we = 1'b1; bus.fwd_mem_rd = 5'd5; bus.fwd_mem_data = 64'h22;
      bus.fwd_wb_we = 1'b1; bus.fwd_wb_rd = 5'd5; bus.fwd_wb_data = 64'h33;
      for (int i = 0; i < 3; i++) begin
         if (i == 1) bus.fwd_mem_we = 1'b0;
         if (i == 2) begin
            bus.fwd_mem_we = 1'b1; bus.fwd_mem_rd = 5'd0; bus.fwd_wb_rd = 5'd0;
            bus.rs2_addr = 5'd0;
         end
         step();
         total++;
         if ({bus.out_valid, bus.fwd_hit, bus.b_out} !== {1'b1, e_t[i], e_b[i]}) begin
            bad++;
            $display("FAIL forward_%0d: got v=%b hit=%b b=%h need v=1 hit=%b b=%h",
                     i, bus.out_valid, bus.fwd_hit, bus.b_out, e_t[i], e_b[i]);
         end
      end
      idle_inputs(); step();
   endtask

   task automatic test_word_mode();
      logic [1:0]  sel [4];
      logic [63:0] e_b [4];
      sel[0] = 2'b01; e_b[0] = 64'hFFFF_FFFF_8000_0000;
      sel[1] = 2'b10; e_b[1] = 64'h0000_0000_7FFF_FFFF;
      sel[2] = 2'b11; e_b[2] = 64'd4;
      sel[3] = 2'b00; e_b[3] = 64'd0;
      bus.in_valid = 1'b1; bus.out_ready = 1'b1; bus.word_mode = 1'b1;
      bus.rs2 = 64'h0000_0001_8000_0000; bus.rs2_addr = 5'd7;
      bus.imm = 64'hFFFF_FFFF_7FFF_FFFF;
      for (int i = 0; i < 4; i++) begin
         bus.bsel = sel[i];
         step();
         total++;
         if ({bus.out_valid, bus.b_out} !== {1'b1, e_b[i]}) begin
            bad++;
            $display("FAIL word_mode_%0d: got v=%b b=%h need v=1 b=%h",
                     i, bus.out_valid, bus.b_out, e_b[i]);
         end
      end
      idle_inputs(); step();
   endtask

   task automatic test_stall();
      logic [63:0] vals [5];
      for (int i = 0; i < 5; i++) vals[i] = 64'hA000 + 64'(i);
      bus.in_valid = 1'b1; bus.out_ready = 1'b1; bus.bsel = 2'b10;
      bus.imm = vals[0];
      step();
      for (int i = 1; i <= 3; i++) begin
         bus.out_ready = 1'b0; bus.imm = vals[i];
         #1;
         total++;
         if (bus.in_ready !== 1'b0) begin
            bad++;
            $display("FAIL stall_in_ready_%0d: got %b need 0", i, bus.in_ready);
         end
         step();
         total++;
         if ({bus.out_valid, bus.b_out} !== {1'b1, vals[0]}) begin
            bad++;
            $display("FAIL stall_hold_%0d: got v=%b b=%h need v=1 b=%h",
                     i, bus.out_valid, bus.b_out, vals[0]);
         end
      end
      bus.out_ready = 1'b1; bus.imm = vals[4];
      #1;
      total++;
      if (bus.in_ready !== 1'b1) begin
         bad++;
         $display("FAIL release_in_ready: got %b need 1", bus.in_ready);
      end
      step();
      total++;
      if ({bus.out_valid, bus.b_out} !== {1'b1, vals[4]}) begin
         bad++;
         $display("FAIL back_to_back: got v=%b b=%h need v=1 b=%h",
                  bus.out_valid, bus.b_out, vals[4]);
      end
      bus.in_valid = 1'b0;
      step();
      total++;
      if ({bus.out_valid, bus.b_out} !== {1'b0, vals[4]}) begin
         bad++;
         $display("FAIL drain_keep: got v=%b b=%h need v=0 b=%h",
                  bus.out_valid, bus.b_out, vals[4]);
      end
      idle_inputs(); step();
   endtask

   task automatic test_flush_reset();
      logic [1:0] t_load;
`ifdef ALU_OPB_FWD_EN
      t_load = 2'b01;
`else
      t_load = 2'b00;
`endif
      // Load a forwarded entry so a flush has a tag to clear.
      bus.in_valid = 1'b1; bus.out_ready = 1'b1; bus.bsel = 2'b01;
      bus.rs2 = 64'h5; bus.rs2_addr = 5'd3;
      bus.fwd_mem_we = 1'b1; bus.fwd_mem_rd = 5'd3; bus.fwd_mem_data = 64'hBEEF;
      step();
      total++;
      if (bus.fwd_hit !== t_load) begin
         bad++;
         $display("FAIL flush_preload_hit: got %b need %b", bus.fwd_hit, t_load);
      end
      bus.out_ready = 1'b0; bus.bsel = 2'b10; bus.imm = 64'h1234; bus.flush = 1'b1;
      step();
      total++;
      if ({bus.out_valid, bus.fwd_hit} !== {1'b0, 2'b00}) begin
         bad++;
         $display("FAIL flush_stall: got v=%b hit=%b need v=0 hit=00",
                  bus.out_valid, bus.fwd_hit);
      end
      bus.flush = 1'b0; bus.imm = 64'h7777;
      step();
      step();
      total++;
      if ({bus.out_valid, bus.b_out} !== {1'b1, 64'h7777}) begin
         bad++;
         $display("FAIL refill_stall: got v=%b b=%h need v=1 b=7777",
                  bus.out_valid, bus.b_out);
      end
      #2 rstn = 1'b0;
      #1;
      total++;
      if ({bus.out_valid, bus.fwd_hit, bus.b_out} !== {1'b0, 2'b00, 64'd0}) begin
         bad++;
         $display("FAIL async_reset: got v=%b hit=%b b=%h need v=0 hit=00 b=0",
                  bus.out_valid, bus.fwd_hit, bus.b_out);
      end
      #1 rstn = 1'b1;
      bus.out_ready = 1'b1; bus.imm = 64'h9999;
      step();
      total++;
      if ({bus.out_valid, bus.b_out} !== {1'b1, 64'h9999}) begin
         bad++;
         $display("FAIL post_reset_accept: got v=%b b=%h need v=1 b=9999",
                  bus.out_valid, bus.b_out);
      end
      idle_inputs(); step();
   endtask

   task automatic test_random();
      logic        m_valid;
      logic [63:0] m_b;
      logic [1:0]  m_t;
      logic [63:0] v;
      logic [1:0]  t;
      logic        acc;
      int          txn;
      m_valid = 1'b0; m_b = bus.b_out; m_t = 2'b00; txn = 0;
      for (int c = 0; c < 300; c++) begin
         bus.in_valid     = ($urandom_range(0, 3) != 0);
         bus.out_ready    = ($urandom_range(0, 2) != 0);
         bus.flush        = ($urandom_range(0, 15) == 0);
         bus.bsel         = 2'($urandom_range(0, 3));
         bus.word_mode    = ($urandom_range(0, 3) == 0);
         bus.rs2          = {$urandom, $urandom};
         bus.imm          = {$urandom, $urandom};
         bus.rs2_addr     = 5'($urandom_range(0, 3));
         bus.fwd_mem_we   = 1'($urandom_range(0, 1));
         bus.fwd_mem_rd   = 5'($urandom_range(0, 3));
         bus.fwd_mem_data = {$urandom, $urandom};
         bus.fwd_wb_we    = 1'($urandom_range(0, 1));
         bus.fwd_wb_rd    = 5'($urandom_range(0, 3));
         bus.fwd_wb_data  = {$urandom, $urandom};
         #1;
         total++;
         if (bus.in_ready !== (!m_valid || bus.out_ready)) begin
            bad++;
            $display("FAIL rand_in_ready c=%0d: got %b need %b",
                     c, bus.in_ready, (!m_valid || bus.out_ready));
         end
         acc = bus.in_valid && (!m_valid || bus.out_ready) && !bus.flush;
         ref_op(bus.bsel, bus.word_mode, bus.rs2, bus.imm, bus.rs2_addr,
                bus.fwd_mem_we, bus.fwd_mem_rd, bus.fwd_mem_data,
                bus.fwd_wb_we, bus.fwd_wb_rd, bus.fwd_wb_data, v, t);
         if (bus.flush) begin
            m_valid = 1'b0; m_t = 2'b00;
         end else if (acc) begin
            m_valid = 1'b1; m_b = v; m_t = t; txn++;
            $display("txn %0d: bsel=%b wm=%b b=%h tag=%b",
                     txn, bus.bsel, bus.word_mode, v, t);
         end else if (bus.out_ready) begin
            m_valid = 1'b0;
         end
         @(posedge clk); #1;
         total++;
         if ({bus.out_valid, bus.fwd_hit, bus.b_out} !== {m_valid, m_t, m_b}) begin
            bad++;
            $display("FAIL rand_out c=%0d: got v=%b hit=%b b=%h need v=%b hit=%b b=%h",
                     c, bus.out_valid, bus.fwd_hit, bus.b_out, m_valid, m_t, m_b);
         end
      end
      idle_inputs(); step();
   endtask

   initial begin
      total = 0;
      bad   = 0;
      test_reset();
      test_imm();
      test_forward();
      test_word_mode();
      test_stall();
      test_flush_reset();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_alu_opb_stage

// File: doc/alu_opb_stage.md
ALU_OPB_STAGE -- requirements
Module: alu_opb_stage

Interface
REQ-001 SHALL take parameter XLEN, default 64: datapath width in bits (legal: 32, 64).
REQ-002 SHALL take parameter RADDR_W, default 5: register-address width.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port rstn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  upstream operand request valid.
REQ-006 SHALL have port in_ready  output  1  stage can accept this cycle.
REQ-007 SHALL have port bsel  input  2  00 zero, 01 rs2, 10 imm, 11 constant 4.
REQ-008 SHALL have port word_mode  input  1  RV64 W-op: sign-extend low 32 bits of result.
REQ-009 SHALL have ports rs2 / imm  input  XLEN each  register-file and immediate operands.
REQ-010 SHALL have port rs2_addr  input  RADDR_W  source register index of rs2.
REQ-011 SHALL have ports fwd_mem_we (1), fwd_mem_rd (RADDR_W), fwd_mem_data (XLEN)  input  MEM-stage forward source.
REQ-012 SHALL have ports fwd_wb_we (1), fwd_wb_rd (RADDR_W), fwd_wb_data (XLEN)  input  WB-stage forward source.
REQ-013 SHALL have port flush  input  1  discard held and incoming operand.
REQ-014 SHALL have port out_valid  output  1  b_out holds a valid operand.
REQ-015 SHALL have port out_ready  input  1  downstream consumes b_out this cycle.
REQ-016 SHALL have port b_out  output  XLEN  registered operand B.
REQ-017 SHALL have port fwd_hit  output  2  registered source tag: 00 none, 01 MEM, 10 WB.

Function
REQ-018 in_ready SHALL equal !out_valid || out_ready (combinational, single-entry register).
REQ-019 Accept SHALL occur when in_valid && in_ready && !flush; latency accept->out_valid = 1 cycle.
REQ-020 On accept, b_out SHALL load the selected value: 0, rs2 (or forwarded), imm, or 4.
REQ-021 Forwarding SHALL apply only when bsel==01; MEM hit = fwd_mem_we && fwd_mem_rd==rs2_addr && rs2_addr!=0; WB hit likewise.
REQ-022 MEM hit SHALL take priority over WB hit; neither hit selects rs2; fwd_hit records the chosen source.
REQ-023 With word_mode=1, b_out SHALL be sign-extension of bits [31:0] of the selected value; word_mode ignored when XLEN==32.
REQ-024 When out_valid && !out_ready, b_out, fwd_hit and out_valid SHALL hold unchanged.
REQ-025 When out_ready && no accept, out_valid SHALL clear next cycle; b_out keeps last value.
REQ-026 Simultaneous out_ready and accept SHALL replace the entry with no bubble.
REQ-027 flush SHALL clear out_valid and fwd_hit next cycle, overriding any accept and any stall.

Reset
REQ-028 rstn low SHALL immediately force out_valid=0, b_out=0, fwd_hit=00 regardless of clk.
REQ-029 Reset asserted mid-stall SHALL drop the held operand; first accept after release behaves per REQ-019.

Configuration
REQ-030 Macro ALU_OPB_FWD_EN defined: forwarding per REQ-021/022 compiled in.
REQ-031 Macro ALU_OPB_FWD_EN undefined: bsel==01 always selects rs2, fwd_hit tied 00, forward ports present but unused.

Structure
REQ-032 Shared package alu_pkg SHALL hold BSEL_ZERO/RS2/IMM/CONST4 codes, FWD_NONE/MEM/WB tags, and constant CONST4 value.
REQ-033 Forward compare/priority SHALL be sub-module alu_opb_fwd_sel (combinational, instantiated only under ALU_OPB_FWD_EN).

Verification
REQ-034 Reset then bsel=10, imm=0xFFFF_FFFF_FFFF_FFF0, in_valid=1, out_ready=1 -> next cycle out_valid=1, b_out=0xFFFF_FFFF_FFFF_FFF0, fwd_hit=00.
REQ-035 bsel=01, rs2_addr=5, rs2=0x11, MEM we/rd=5 data=0x22, WB we/rd=5 data=0x33 -> b_out=0x22, fwd_hit=01; MEM we=0 -> b_out=0x33, fwd_hit=10; rs2_addr=0 -> 0x11, 00.
REQ-036 word_mode=1, bsel=01, rs2=0x0000_0001_8000_0000 -> b_out=0xFFFF_FFFF_8000_0000.
REQ-037 out_ready=0 for 3 cycles with in_valid=1 and changing imm -> in_ready=0, b_out frozen at first value; out_ready=1 -> next entry loads with no bubble.
REQ-038 flush during stall with in_valid=1 -> out_valid=0 next cycle, no new entry; rstn pulsed low mid-stall -> b_out=0 asynchronously.
